uart_fifo_core: RTL and testbench
=================================

# uart_fifo_core

Single-clock, runtime-configurable UART with TX and RX FIFOs. It replaces the split baud-clock architecture with one system clock and an oversample tick enable, so the block has no internal clock-domain crossings. Word length, FIFO depth and oversample ratio are parameters. Baud divisor, parity, stop bits, loopback and flow control are set at runtime. The RX side adds per-word error flags (parity, framing, break) and a sticky overrun flag. The block sits between the bus-side register interface and the UART pins.

## Interface
- `DataWidth`, 8: data bits per frame (5..9), sent LSB first.
- `FifoDepth`, 16: entries per FIFO (power of 2, ≥2).
- `OverSample`, 16: ticks per bit (even, ≥4).
- `DivWidth`, 16: width of `i_divisor`.

Ports (clock and reset first):
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_divisor`  in  DivWidth  tick period minus 1 (clocks).
- `i_parity_en`  in  1  parity bit present.
- `i_parity_odd`  in  1  1 = odd parity, 0 = even parity.
- `i_two_stop`  in  1  TX sends 2 stop bits (RX always checks 1).
- `i_loopback`  in  1  RX is fed from the internal TX serial stream; `o_tx` is held 1.
- `i_flow_en`  in  1  enables CTS gating and RTS output.
- `i_tx_data`  in  DataWidth  word to send.
- `i_tx_valid`  in  1  push request.
- `o_tx_ready`  out  1  TX FIFO not full.
- `o_rx_data`  out  DataWidth  RX FIFO head (first-word fall-through).
- `o_rx_status`  out  3  head flags {break, frame_err, parity_err}.
- `o_rx_valid`  out  1  RX FIFO not empty.
- `i_rx_ready`  in  1  pop request.
- `o_overrun`  out  1  sticky: an RX word was dropped because the FIFO was full.
- `i_clr_overrun`  in  1  clears `o_overrun`.
- `o_tx_busy`  out  1  TX frame in progress, or TX FIFO non-empty.
- `i_rx`  in  1  serial input (asynchronous).
- `o_tx`  out  1  serial output.
- `i_cts`  in  1  peer may receive (active high).
- `o_rts`  out  1  `~rx_full` when `i_flow_en`, else 1.

## Operation
- **Tick generator**
  - Counter runs 0..`i_divisor`; `tick` pulses on wrap, i.e. every `i_divisor`+1 clocks.
  - `i_divisor` is re-read at each wrap.
  - Bit time = OverSample·(div+1) clocks.
- **Handshakes**
  - A push happens when `i_tx_valid` & `o_tx_ready`.
  - A pop happens when `o_rx_valid` & `i_rx_ready`.
  - Pushing while full, or popping while empty, is ignored.
- **RX input sync:** 2-FF synchroniser, reset value 1. In loopback, the synchroniser input is the internal TX line.
- **RX FSM** (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH); all transitions are tick-qualified.
  - IDLE: line low → START, tick count cleared.
  - START: at OverSample/2 ticks, sample the line. High → IDLE (glitch rejected). Low → DATA.
  - DATA: sample every OverSample ticks; DataWidth samples.
  - PARITY (only if `i_parity_en`): parity_err = received parity bit ≠ expected parity bit.
  - STOP: sample the stop bit.
    - Stop bit low → frame_err = 1.
    - Stop bit low, all data bits 0, and parity (if present) 0 → break = 1.
    - Then push {status, data}. If RX FIFO is full, drop the word and set `o_overrun`.
    - Next state: IDLE if the stop bit is high, else WAIT_HIGH.
  - WAIT_HIGH: stay until the line reads 1, then IDLE.
  - Config inputs are latched at the START→DATA transition.
- **TX FSM** (IDLE, START, DATA, PARITY, STOP1, STOP2); advances only on ticks; each bit lasts OverSample ticks.
  - IDLE: on a tick with TX FIFO non-empty and (`!i_flow_en` | `i_cts`), pop the word, latch config, go to START.
  - Bit order: START drives 0; DATA drives LSB first; PARITY drives the parity bit (if `i_parity_en`); STOP1 drives 1; STOP2 (if `i_two_stop`) drives 1.
  - After the last stop bit → IDLE, which can start the next frame on the same tick, so back-to-back frames have no gap.
  - CTS is checked only in IDLE. Deasserting it mid-frame does not abort the current frame.
- **Simultaneous events**
  - RX push and pop in the same cycle while full: both proceed, and no overrun is flagged.
  - `i_clr_overrun` and a new overrun in the same cycle: the flag ends up set.
- **Config changes:** a change mid-frame affects only the next frame, except `i_divisor`, which takes effect at the next wrap.

## Timing
- **Reset values**
  - `o_tx`=1, `o_tx_ready`=1, `o_rx_valid`=0.
  - `o_rx_data`=0, `o_rx_status`=0.
  - `o_overrun`=0, `o_tx_busy`=0, `o_rts`=1.
  - FIFOs empty, both FSMs in IDLE, tick counter 0.
- **Reset mid-frame:** the frame is abandoned and outputs take their reset values in the cycle after `i_rst` is sampled high.
- **TX latency:** from push to the `o_tx` falling edge is ≤ div+3 clocks. `o_tx` changes in the cycle after the tick that advances the FSM.
- **RX latency:** `o_rx_valid` rises 2 clocks after the tick on which the stop bit is sampled.
- **RX data path:** `o_rx_data`/`o_rx_status` reflect the new head the cycle after a pop.
- **RTS:** `o_rts` is registered from the FIFO count and updates 1 clock after a push or pop.

## Test plan
- **Loopback 8N1:** DataWidth=8, OverSample=16, div=0, loopback on; push 0x55 → each bit is 16 clocks on the internal line; 0x55 appears at `o_rx_data` with status 000; the frame is 160 clocks.
- **Parity:** parity_en, even; push 0xA5 → parity bit 0, received status 000. Drive an external frame carrying 0xA5 with parity bit 1 → status 001, and data 0xA5 is still stored.
- **Framing and break:**
  - Drive 0x3C with a low stop bit → status 010.
  - Hold `i_rx` low for 12 bit times → data 0x00, status 110, and exactly one word stored until the line returns high.
- **Overrun:** FifoDepth=4; receive 5 words with no pops → 4 words kept, `o_overrun`=1, `o_rts`=0. Pulse `i_clr_overrun` → flag 0.
- **Flow control:**
  - `i_flow_en`=1, `i_cts`=0, 2 words queued → `o_tx` stays 1.
  - Raise `i_cts` → start bit within div+3 clocks.
  - Drop `i_cts` mid-frame → the first frame completes and the second does not start.
- **Glitch and reset:**
  - A 4-clock low pulse on `i_rx` at div=0 → no word.
  - Assert `i_rst` during TX data bit 3 → `o_tx`=1 and `o_tx_busy`=0 in the next cycle, and nothing is received afterwards.

Source files
------------

// File: rtl/uart_fifo_core.sv
// uart_fifo_core: single-clock UART with TX/RX FIFOs, driven by an
// oversample tick enable derived from the system clock.
//
// Ports:
//   i_clk, i_rst             system clock, synchronous active-high reset
//   i_divisor                tick period minus 1, in clocks
//   i_parity_en/_odd         parity present / odd parity select
//   i_two_stop               TX sends two stop bits
//   i_loopback               RX fed from internal TX line, o_tx held high
//   i_flow_en, i_cts, o_rts  hardware flow control
//   i_tx_data/_valid, o_tx_ready                TX FIFO push side
//   o_rx_data/_status/_valid, i_rx_ready        RX FIFO pop side (FWFT)
//   o_overrun, i_clr_overrun sticky RX drop flag
//   o_tx_busy                frame in flight or TX FIFO non-empty
//   i_rx, o_tx               serial pins
module uart_fifo_core #(
  parameter int DataWidth  = 8,
  parameter int FifoDepth  = 16,
  parameter int OverSample = 16,
  parameter int DivWidth   = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [DivWidth-1:0]  i_divisor,
  input  logic                 i_parity_en,
  input  logic                 i_parity_odd,
  input  logic                 i_two_stop,
  input  logic                 i_loopback,
  input  logic                 i_flow_en,
  input  logic [DataWidth-1:0] i_tx_data,
  input  logic                 i_tx_valid,
  output logic                 o_tx_ready,
  output logic [DataWidth-1:0] o_rx_data,
  output logic [2:0]           o_rx_status,
  output logic                 o_rx_valid,
  input  logic                 i_rx_ready,
  output logic                 o_overrun,
  input  logic                 i_clr_overrun,
  output logic                 o_tx_busy,
  input  logic                 i_rx,
  output logic                 o_tx,
  input  logic                 i_cts,
  output logic                 o_rts
);
  localparam int AW = $clog2(FifoDepth);
  localparam int CW = AW + 1;
  localparam int OW = $clog2(OverSample);
  localparam int BW = $clog2(DataWidth + 1);
  localparam int RW = DataWidth + 3;

  // Tick generator; the divisor is only picked up at wrap so a live change
  // never strands the counter above the compare value.
  logic [DivWidth-1:0] div_cnt, div_q;
  logic                tick;
  assign tick = (div_cnt == div_q);
  always_ff @(posedge i_clk) begin
    if (i_rst || tick) begin
      div_cnt <= '0;
      div_q   <= i_divisor;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // TX FIFO
  logic [DataWidth-1:0] tx_mem [FifoDepth];
  logic [AW-1:0]        tx_wp, tx_rp;
  logic [CW-1:0]        tx_cnt;
  logic                 tx_push, tx_pop;
  assign o_tx_ready = (tx_cnt != CW'(FifoDepth));
  assign tx_push    = i_tx_valid & o_tx_ready;

  always_ff @(posedge i_clk) if (tx_push) tx_mem[tx_wp] <= i_tx_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  // TX FSM
  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP1, T_STOP2} tx_st_e;
  tx_st_e               tx_st;
  logic [OW-1:0]        tx_tc;
  logic [BW-1:0]        tx_bc;
  logic [DataWidth-1:0] tx_sh;
  logic                 tx_par_en, tx_par_bit, tx_two, tx_line;
  logic                 tx_can_start, tx_bit_end, tx_frame_end;

  assign tx_can_start = (tx_cnt != '0) & (~i_flow_en | i_cts);
  assign tx_bit_end   = tick & (tx_tc == OW'(OverSample - 1));
  assign tx_frame_end = tx_bit_end & ((tx_st == T_STOP2) | ((tx_st == T_STOP1) & ~tx_two));
  // Popping on the tick that ends the last stop bit gives gapless frames.
  assign tx_pop       = tick & tx_can_start & ((tx_st == T_IDLE) | tx_frame_end);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tx_st <= T_IDLE; tx_line <= 1'b1; tx_tc <= '0; tx_bc <= '0; tx_sh <= '0;
      tx_par_en <= 1'b0; tx_par_bit <= 1'b0; tx_two <= 1'b0;
    end else if (tx_pop) begin
      tx_st      <= T_START;
      tx_line    <= 1'b0;
      tx_tc      <= '0;
      tx_sh      <= tx_mem[tx_rp];
      tx_par_en  <= i_parity_en;
      tx_par_bit <= (^tx_mem[tx_rp]) ^ i_parity_odd;
      tx_two     <= i_two_stop;
    end else if (tx_frame_end) begin
      tx_st <= T_IDLE; tx_line <= 1'b1; tx_tc <= '0;
    end else if (tick && tx_st != T_IDLE) begin
      if (!tx_bit_end) begin
        tx_tc <= tx_tc + 1'b1;
      end else begin
        tx_tc <= '0;
        case (tx_st)
          T_START: begin
            tx_st <= T_DATA; tx_line <= tx_sh[0]; tx_sh <= tx_sh >> 1; tx_bc <= BW'(1);
          end
          T_DATA:
            if (tx_bc == BW'(DataWidth)) begin
              if (tx_par_en) begin tx_st <= T_PAR;   tx_line <= tx_par_bit; end
              else           begin tx_st <= T_STOP1; tx_line <= 1'b1;       end
            end else begin
              tx_line <= tx_sh[0]; tx_sh <= tx_sh >> 1; tx_bc <= tx_bc + 1'b1;
            end
          T_PAR:   begin tx_st <= T_STOP1; tx_line <= 1'b1; end
          T_STOP1: tx_st <= T_STOP2;  // single-stop frames leave via tx_frame_end
          default: tx_st <= T_IDLE;
        endcase
      end
    end
  end

  assign o_tx      = i_loopback ? 1'b1 : tx_line;
  assign o_tx_busy = (tx_st != T_IDLE) | (tx_cnt != '0);

  // RX synchroniser, idles high
  logic [1:0] rx_sync;
  logic       rx_s;
  always_ff @(posedge i_clk) begin
    if (i_rst) rx_sync <= 2'b11;
    else       rx_sync <= {rx_sync[0], i_loopback ? tx_line : i_rx};
  end
  assign rx_s = rx_sync[1];

  // RX FSM
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_WAIT} rx_st_e;
  rx_st_e               rx_st;
  logic [OW-1:0]        rx_tc;
  logic [BW-1:0]        rx_bc;
  logic [DataWidth-1:0] rx_sh;
  logic                 rx_par_en, rx_par_odd, rx_perr, rx_pbit, rx_wr;
  logic [RW-1:0]        rx_wd;   // {break, frame_err, parity_err, data}
  logic                 rx_bit_end;
  assign rx_bit_end = (rx_tc == OW'(OverSample - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_st <= R_IDLE; rx_tc <= '0; rx_bc <= '0; rx_sh <= '0;
      rx_par_en <= 1'b0; rx_par_odd <= 1'b0; rx_perr <= 1'b0; rx_pbit <= 1'b0;
      rx_wr <= 1'b0; rx_wd <= '0;
    end else begin
      rx_wr <= 1'b0;
      if (tick) begin
        case (rx_st)
          R_IDLE: if (!rx_s) begin rx_st <= R_START; rx_tc <= '0; end
          R_START:
            if (rx_tc == OW'(OverSample / 2 - 1)) begin
              rx_tc <= '0;
              if (rx_s) rx_st <= R_IDLE;  // glitch
              else begin
                rx_st <= R_DATA; rx_bc <= '0; rx_perr <= 1'b0; rx_pbit <= 1'b0;
                rx_par_en <= i_parity_en; rx_par_odd <= i_parity_odd;
              end
            end else rx_tc <= rx_tc + 1'b1;
          R_DATA:
            if (rx_bit_end) begin
              rx_tc <= '0;
              rx_sh <= {rx_s, rx_sh[DataWidth-1:1]};
              rx_bc <= rx_bc + 1'b1;
              if (rx_bc == BW'(DataWidth - 1)) rx_st <= rx_par_en ? R_PAR : R_STOP;
            end else rx_tc <= rx_tc + 1'b1;
          R_PAR:
            if (rx_bit_end) begin
              rx_tc   <= '0;
              rx_pbit <= rx_s;
              rx_perr <= rx_s ^ (^rx_sh) ^ rx_par_odd;
              rx_st   <= R_STOP;
            end else rx_tc <= rx_tc + 1'b1;
          R_STOP:
            if (rx_bit_end) begin
              rx_tc <= '0;
              rx_wr <= 1'b1;
              rx_wd <= {~rx_s & (rx_sh == '0) & ~(rx_par_en & rx_pbit),
                        ~rx_s, rx_par_en & rx_perr, rx_sh};
              rx_st <= rx_s ? R_IDLE : R_WAIT;
            end else rx_tc <= rx_tc + 1'b1;
          R_WAIT:  if (rx_s) rx_st <= R_IDLE;
          default: rx_st <= R_IDLE;
        endcase
      end
    end
  end

  // RX FIFO, one cycle behind the FSM. A pop in the same cycle frees the slot,
  // so push+pop while full is not an overrun.
  logic [RW-1:0] rx_mem [FifoDepth];
  logic [AW-1:0] rx_wp, rx_rp;
  logic [CW-1:0] rx_cnt;
  logic          rx_full, rx_push, rx_pop, rx_drop;
  assign rx_full    = (rx_cnt == CW'(FifoDepth));
  assign o_rx_valid = (rx_cnt != '0);
  assign rx_pop     = o_rx_valid & i_rx_ready;
  assign rx_push    = rx_wr & (~rx_full | rx_pop);
  assign rx_drop    = rx_wr & rx_full & ~rx_pop;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0; o_overrun <= 1'b0; o_rts <= 1'b1;
      for (int i = 0; i < FifoDepth; i++) rx_mem[i] <= '0;
    end else begin
      if (rx_push) begin rx_mem[rx_wp] <= rx_wd; rx_wp <= rx_wp + 1'b1; end
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase
      o_overrun <= rx_drop | (o_overrun & ~i_clr_overrun);
      o_rts     <= ~i_flow_en | ~rx_full;
    end
  end

  assign o_rx_data   = rx_mem[rx_rp][DataWidth-1:0];
  assign o_rx_status = rx_mem[rx_rp][RW-1:DataWidth];
endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench for uart_fifo_core. Expected RX words are queued as the
// stimulus is issued; a negedge monitor pops and compares whenever the DUT
// hands a word over. TX line timing is measured directly on o_tx, which is
// normally fed back to i_rx; ext_mode lets the bench drive i_rx itself.
module tb_uart_fifo_core;
  localparam int DW = 8, DEPTH = 4, OS = 16, DIVW = 16;

  logic            i_clk = 1'b0, i_rst = 1'b1;
  logic [DIVW-1:0] i_divisor = '0;
  logic            i_parity_en = 1'b0, i_parity_odd = 1'b0, i_two_stop = 1'b0;
  logic            i_loopback = 1'b0, i_flow_en = 1'b0, i_cts = 1'b1;
  logic [DW-1:0]   i_tx_data = '0;
  logic            i_tx_valid = 1'b0, o_tx_ready;
  logic [DW-1:0]   o_rx_data;
  logic [2:0]      o_rx_status;
  logic            o_rx_valid, i_rx_ready = 1'b1;
  logic            o_overrun, i_clr_overrun = 1'b0, o_tx_busy;
  logic            i_rx, o_tx, o_rts;
  logic            ext_mode = 1'b0, ext_rx = 1'b1;

  assign i_rx = ext_mode ? ext_rx : o_tx;

  uart_fifo_core #(.DataWidth(DW), .FifoDepth(DEPTH), .OverSample(OS), .DivWidth(DIVW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_divisor(i_divisor),
    .i_parity_en(i_parity_en), .i_parity_odd(i_parity_odd), .i_two_stop(i_two_stop),
    .i_loopback(i_loopback), .i_flow_en(i_flow_en),
    .i_tx_data(i_tx_data), .i_tx_valid(i_tx_valid), .o_tx_ready(o_tx_ready),
    .o_rx_data(o_rx_data), .o_rx_status(o_rx_status), .o_rx_valid(o_rx_valid),
    .i_rx_ready(i_rx_ready), .o_overrun(o_overrun), .i_clr_overrun(i_clr_overrun),
    .o_tx_busy(o_tx_busy), .i_rx(i_rx), .o_tx(o_tx), .i_cts(i_cts), .o_rts(o_rts)
  );

  always #5 i_clk = ~i_clk;

  int          n_chk = 0, n_pass = 0;
  logic [10:0] exp_q [$];   // {break, frame_err, parity_err, data}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  task automatic push_tx(input logic [DW-1:0] d);
    i_tx_data = d; i_tx_valid = 1'b1;
    step(1);
    i_tx_valid = 1'b0;
  endtask

  task automatic wait_tx(input logic lvl, input int limit, output int cyc);
    cyc = 0;
    while (o_tx !== lvl && cyc < limit) begin step(1); cyc++; end
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic has_par,
                            input logic par, input logic stop);
    int bt;
    bt = OS * (int'(i_divisor) + 1);
    ext_rx = 1'b0; step(bt);
    for (int i = 0; i < DW; i++) begin ext_rx = d[i]; step(bt); end
    if (has_par) begin ext_rx = par; step(bt); end
    ext_rx = stop; step(bt);
    ext_rx = 1'b1; step(2 * bt);
  endtask

  // Scoreboard monitor
  always @(negedge i_clk) begin
    if (!i_rst && o_rx_valid && i_rx_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL rx_unexpected: got %0h, required no word", {o_rx_status, o_rx_data});
      end else begin
        check("rx_word", {o_rx_status, o_rx_data}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, w, last, lows;
    logic prev;

    // reset values
    step(3);
    check("rst_tx", o_tx, 1);
    check("rst_tx_ready", o_tx_ready, 1);
    check("rst_rx_valid", o_rx_valid, 0);
    check("rst_rx_head", {o_rx_status, o_rx_data}, 0);
    check("rst_ovr_busy_rts", {o_overrun, o_tx_busy, o_rts}, 3'b001);
    i_rst = 1'b0; step(2);

    // 8N1 on the pin, fed back to i_rx: 16-clock bits, last rise at 144
    exp_q.push_back(11'h055);
    push_tx(8'h55);
    wait_tx(1'b0, 10, c);
    check("tx_start_latency_ok", c <= 3, 1);
    wait_tx(1'b1, 40, w);
    check("tx_start_width", w, 16);
    last = 0;
    for (int i = 1; i <= 200; i++) begin
      prev = o_tx; step(1);
      if (!prev && o_tx) last = i;
    end
    check("tx_last_rise", 16 + last, 144);
    check("tx_rx_done", exp_q.size(), 0);

    // internal loopback: pin stays high, word still arrives
    i_loopback = 1'b1;
    exp_q.push_back(11'h055);
    push_tx(8'h55);
    lows = 0;
    for (int i = 0; i < 220; i++) begin if (o_tx !== 1'b1) lows++; step(1); end
    check("loopback_tx_high", lows, 0);
    check("loopback_rx_done", exp_q.size(), 0);
    i_loopback = 1'b0;

    // even parity: 0xA5 has four ones -> parity bit 0
    i_parity_en = 1'b1;
    exp_q.push_back(11'h0A5);
    push_tx(8'hA5);
    wait_tx(1'b0, 10, c);
    step(152);
    check("tx_parity_bit", o_tx, 0);
    step(100);
    ext_mode = 1'b1;
    exp_q.push_back(11'h1A5);       // wrong parity bit, data still stored
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
    step(4);
    check("parity_err_done", exp_q.size(), 0);
    i_parity_en = 1'b0;

    // framing error
    exp_q.push_back(11'h23C);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    step(4);
    check("frame_err_done", exp_q.size(), 0);

    // break: line low for 12 bit times, exactly one word
    exp_q.push_back(11'h600);
    ext_rx = 1'b0; step(12 * OS);
    ext_rx = 1'b1; step(4 * OS);
    check("break_done", exp_q.size(), 0);

    // overrun: 5 words into a 4-deep FIFO with no pops
    i_flow_en = 1'b1; i_rx_ready = 1'b0;
    for (int k = 1; k <= 4; k++) exp_q.push_back(11'(k));
    for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b0, 1'b0, 1'b1);
    check("overrun_set", o_overrun, 1);
    check("rts_full", o_rts, 0);
    i_clr_overrun = 1'b1; step(1); i_clr_overrun = 1'b0;
    check("overrun_clr", o_overrun, 0);
    i_rx_ready = 1'b1; step(10);
    check("overrun_drain", exp_q.size(), 0);
    check("rts_drained", o_rts, 1);

    // flow control at div=2
    ext_mode = 1'b0; i_divisor = 16'd2; i_cts = 1'b0; step(2);
    push_tx(8'h11); push_tx(8'h22);
    lows = 0;
    for (int i = 0; i < 100; i++) begin if (o_tx !== 1'b1) lows++; step(1); end
    check("cts_hold_tx_high", lows, 0);
    check("cts_hold_busy", o_tx_busy, 1);
    exp_q.push_back(11'h011);
    i_cts = 1'b1;
    wait_tx(1'b0, 20, c);
    check("cts_start_latency_ok", c <= 5, 1);
    step(100);
    i_cts = 1'b0;                   // mid-frame: first frame finishes, second waits
    step(1000);
    check("cts_first_done", exp_q.size(), 0);
    check("cts_second_held", {o_tx, o_tx_busy}, 2'b11);
    exp_q.push_back(11'h022);
    i_cts = 1'b1; step(700);
    check("cts_second_done", exp_q.size(), 0);
    i_flow_en = 1'b0; i_divisor = '0; step(10);

    // 4-clock glitch is rejected
    ext_mode = 1'b1;
    ext_rx = 1'b0; step(4); ext_rx = 1'b1;
    step(300);
    check("glitch_no_word", o_rx_valid, 0);

    // reset during TX data bit 3
    ext_mode = 1'b0;
    push_tx(8'h00);
    wait_tx(1'b0, 10, c);
    step(70);
    check("pre_reset_tx_low", o_tx, 0);
    i_rst = 1'b1; step(1);
    check("reset_mid_tx", {o_tx, o_tx_busy}, 2'b10);
    i_rst = 1'b0; step(400);
    check("reset_no_word", o_rx_valid, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
